bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 150 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam int DEF_BIN_W  = 14;
    localparam int DEF_DIGITS = 4;
    localparam int DEF_CNT_W  = $clog2(DEF_BIN_W + 1);

    // Bit counter width: must hold the load value BIN_W.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // 10^n as a 64-bit constant; n up to 10 fits comfortably.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit correction step of shift-and-add-3: digits >= 5 get +3.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done
// handshake, overflow saturation and leading-zero blanking mask.
//
// state | meaning
// IDLE  | waiting for iStart; outputs hold the last result
// CONV  | one correct-and-shift per cycle, BIN_W cycles total
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic [BIN_W-1:0]      iBin,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [4*DIGITS-1:0]   oBcd,
    output logic [DIGITS-1:0]     oBlank,
    output logic                  oOverflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};

    // Largest displayable value and largest input; overflow is only
    // possible when the input range exceeds the display range.
    localparam logic [63:0] LIMIT64   = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] BIN_MAX64 = (64'd1 << BIN_W) - 64'd1;
    localparam bit          CAN_OVF   = (BIN_MAX64 > LIMIT64);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_final;
    logic [DIGITS-1:0]  blank_calc;
    logic               ovf_in;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_add3
            bcd_add3 u_add3 (
                .d_i (sr_q[BIN_W + 4*k +: 4]),
                .d_o (bcd_adj[4*k +: 4])
            );
        end

        if (CAN_OVF) begin : g_ovf
            localparam logic [BIN_W:0] LIMIT = LIMIT64[BIN_W:0];
            assign ovf_in = ({1'b0, iBin} > LIMIT);
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    // Top bit of the BCD field falls off; binary MSB enters digit 0 LSB.
    assign sr_adj    = {bcd_adj, sr_q[BIN_W-1:0]};
    assign sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
    assign bcd_final = sr_shift[SR_W-1 -: BCD_W];

    // Leading-zero mask from the top digit down; digit 0 always shown.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_calc = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (bcd_final[4*k +: 4] == 4'h0);
            blank_calc[k] = zero_run;
        end
        blank_calc[0] = 1'b0;
    end

    // Next-state and datapath update for the IDLE/CONV sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    sr_d       = {{BCD_W{1'b0}}, iBin};
                    cnt_d      = CNT_LOAD;
                    ovf_pend_d = ovf_in;
                    state_d    = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_pend_q;
                    bcd_d   = ovf_pend_q ? NINES : bcd_final;
                    blank_d = ovf_pend_q ? '0 : blank_calc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any conversion in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign oBusy     = (state_q == CONV);
    assign oDone     = done_q;
    assign oBcd      = bcd_q;
    assign oBlank    = blank_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default instance (14-bit/4-digit) and a
// 20-bit/6-digit instance, both checked every cycle against an
// arithmetic model, plus literal expectations from hand calculation.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        startA, busyA, doneA, ovfA;
    logic [13:0] binA;
    logic [15:0] bcdA;
    logic [3:0]  blankA;

    logic        startB, busyB, doneB, ovfB;
    logic [19:0] binB;
    logic [23:0] bcdB;
    logic [5:0]  blankB;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iStart(startA), .iBin(binA),
        .oBusy(busyA), .oDone(doneA), .oBcd(bcdA), .oBlank(blankA),
        .oOverflow(ovfA)
    );

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iStart(startB), .iBin(binB),
        .oBusy(busyB), .oDone(doneB), .oBcd(bcdB), .oBlank(blankB),
        .oOverflow(ovfB)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned m_pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic m_ovf(input longint unsigned v, input int digits);
        return v > (m_pow10(digits) - 1);
    endfunction

    function automatic logic [39:0] m_bcd(input longint unsigned v, input int digits);
        logic [39:0] r = '0;
        longint unsigned x = v;
        for (int k = 0; k < digits; k++) begin
            if (m_ovf(v, digits)) r[4*k +: 4] = 4'd9;
            else begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [9:0] m_blank(input logic [39:0] b, input int digits);
        logic [9:0] r = '0;
        bit z = 1'b1;
        for (int k = digits - 1; k >= 1; k--) begin
            z = z && (b[4*k +: 4] == 4'd0);
            r[k] = z;
        end
        return r;
    endfunction

    int              remA = 0, remB = 0;
    longint unsigned valA = 0, valB = 0;
    logic            doneA_m = 0, ovfA_m = 0, doneB_m = 0, ovfB_m = 0;
    logic [39:0]     bcdA_m = '0, bcdB_m = '0;
    logic [9:0]      blankA_m = '0, blankB_m = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remA = 0; doneA_m = 0; bcdA_m = '0; blankA_m = '0; ovfA_m = 0;
        end else begin
            doneA_m = 0;
            if (remA > 0) begin
                remA--;
                if (remA == 0) begin
                    doneA_m  = 1;
                    bcdA_m   = m_bcd(valA, 4);
                    blankA_m = m_blank(bcdA_m, 4);
                    ovfA_m   = m_ovf(valA, 4);
                end
            end else if (startA) begin
                valA = binA;
                remA = 14;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remB = 0; doneB_m = 0; bcdB_m = '0; blankB_m = '0; ovfB_m = 0;
        end else begin
            doneB_m = 0;
            if (remB > 0) begin
                remB--;
                if (remB == 0) begin
                    doneB_m  = 1;
                    bcdB_m   = m_bcd(valB, 6);
                    blankB_m = m_blank(bcdB_m, 6);
                    ovfB_m   = m_ovf(valB, 6);
                end
            end else if (startB) begin
                valB = binB;
                remB = 20;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_busy",  busyA,  64'(remA > 0));
            check("a_done",  doneA,  doneA_m);
            check("a_bcd",   bcdA,   bcdA_m[15:0]);
            check("a_blank", blankA, blankA_m[3:0]);
            check("a_ovf",   ovfA,   ovfA_m);
            check("b_busy",  busyB,  64'(remB > 0));
            check("b_done",  doneB,  doneB_m);
            check("b_bcd",   bcdB,   bcdB_m[23:0]);
            check("b_blank", blankB, blankB_m[5:0]);
            check("b_ovf",   ovfB,   ovfB_m);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_go(input bit which, input logic [19:0] v);
        @(negedge clk);
        if (which) begin startB = 1'b1; binB = v; end
        else begin startA = 1'b1; binA = v[13:0]; end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic wait_done(input bit which, output int n);
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if ((which ? doneB : doneA) == 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no oDone on instance %0d within 100 cycles", which);
    endtask

    typedef struct {
        int          v;
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
    } vec_t;

    vec_t tbl[5];
    int   n;
    int   dcount;

    initial begin
        tbl[0] = '{1234,  16'h1234, 4'b0000, 1'b0};
        tbl[1] = '{57,    16'h0057, 4'b1100, 1'b0};
        tbl[2] = '{0,     16'h0000, 4'b1110, 1'b0};
        tbl[3] = '{9999,  16'h9999, 4'b0000, 1'b0};
        tbl[4] = '{16383, 16'h9999, 4'b0000, 1'b1};

        rst_n = 1'b1; startA = 1'b0; startB = 1'b0; binA = '0; binB = '0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        #2;
        check("rst_busy", busyA, 0);
        check("rst_done", doneA, 0);
        check("rst_bcd",  bcdA,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the default instance.
        foreach (tbl[i]) begin
            start_go(0, 20'(tbl[i].v));
            wait_done(0, n);
            check("a_latency", n, 14);
            check("a_lit_bcd", bcdA, tbl[i].bcd);
            check("a_lit_blank", blankA, tbl[i].blank);
            check("a_lit_ovf", ovfA, tbl[i].ovf);
        end

        // Start while busy is ignored; start in the done cycle is taken.
        start_go(0, 20'd1234);
        repeat (4) @(negedge clk);
        startA = 1'b1; binA = 14'd42;
        @(negedge clk);
        startA = 1'b0;
        wait_done(0, n);
        check("busy_ignore_lat", n, 9);
        check("busy_ignore_bcd", bcdA, 16'h1234);
        startA = 1'b1; binA = 14'd42;
        @(negedge clk);
        startA = 1'b0;
        wait_done(0, n);
        check("b2b_period", n + 1, 15);
        check("b2b_bcd", bcdA, 16'h0042);
        check("b2b_blank", blankA, 4'b1100);

        // Asynchronous reset in the middle of a conversion.
        start_go(0, 20'd9999);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busyA, 0);
        check("midrst_bcd", bcdA, 0);
        check("midrst_blank", blankA, 0);
        check("midrst_ovf", ovfA, 0);
        check("midrst_done", doneA, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (doneA) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        start_go(0, 20'd808);
        wait_done(0, n);
        check("after_rst_bcd", bcdA, 16'h0808);
        check("after_rst_blank", blankA, 4'b1000);

        // A few random values on the default instance.
        repeat (10) begin
            start_go(0, 20'($urandom_range(0, 16383)));
            wait_done(0, n);
        end

        // Wider instance: boundaries, then random values.
        start_go(1, 20'd999999);
        wait_done(1, n);
        check("b_latency", n, 20);
        check("b_999999_bcd", bcdB, 24'h999999);
        check("b_999999_ovf", ovfB, 0);
        check("b_999999_blank", blankB, 0);
        start_go(1, 20'd1000000);
        wait_done(1, n);
        check("b_1e6_bcd", bcdB, 24'h999999);
        check("b_1e6_ovf", ovfB, 1);
        check("b_1e6_blank", blankB, 0);
        start_go(1, 20'd500000);
        wait_done(1, n);
        check("b_500000_bcd", bcdB, 24'h500000);
        check("b_500000_ovf", ovfB, 0);
        start_go(1, 20'd7);
        wait_done(1, n);
        check("b_7_bcd", bcdB, 24'h000007);
        check("b_7_blank", blankB, 6'b111110);
        repeat (30) begin
            start_go(1, 20'($urandom_range(0, 20'hFFFFF)));
            wait_done(1, n);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
